interrupt_arbiter: RTL and testbench

- Shares the single upstream action interrupt channel (req/src/ctx/ack) among N_ENGINES engine helpers.
- Each engine helper emits a one-cycle interrupt request pulse with its source and context, then waits for an ack.
- This block latches each request, arbitrates round-robin, and forwards one request at a time upstream with a level-held req.
- It returns a one-cycle ack to the granted engine.

---
 rtl/interrupt_arbiter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_interrupt_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_arbiter.sv
// ============================================================================
// interrupt_arbiter
// ----------------------------------------------------------------------------
// Shares one upstream interrupt channel (req/src/ctx/ack) among N_ENGINES
// engine helpers. Each engine sends a one-cycle request pulse carrying its
// source and context. The pulse is latched into a per-engine pending slot.
// A round-robin arbiter grants one slot at a time. The granted slot is
// forwarded upstream with a level-held request. When the upstream ack
// arrives, a one-cycle ack returns to the granted engine.
//
// Optional feature (compile-time macro INTR_ARB_TIMEOUT_EN):
//   When defined, an upstream ack timeout of TIMEOUT_CYCLES cycles spent in
//   REQ retires the grant anyway and sets err_timeout[g]. The engine is
//   still acked, so it cannot lock up. When undefined, REQ waits
//   indefinitely and err_timeout is tied to 0.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   eng_intr_req      [N]        per-engine one-cycle request pulse
//   eng_intr_src      [N*SRCW]   per-engine source, slice i = [i*SRCW +: SRCW]
//   eng_intr_ctx      [N*CTXW]   per-engine context, slice i = [i*CTXW +: CTXW]
//   eng_intr_ack      [N]        one-cycle ack to the granted engine
//   intr_req/src/ctx  upstream request; src/ctx stay stable while req=1
//   intr_ack          upstream one-cycle ack (ignored outside REQ)
//   pending           [N]        per-engine pending flags
//   err_overflow      [N]        sticky: pulse arrived while already pending
//   err_timeout       [N]        sticky: upstream ack timeout
//   err_clr           clears all sticky error bits (wins over a same-cycle set)
//   busy              any pending, or FSM not in IDLE
//
// Handshake: intr_req rises the cycle after a grant and stays high until the
// cycle after intr_ack=1 is sampled in REQ. eng_intr_ack[g] is high for
// exactly the following cycle.
// ============================================================================
module interrupt_arbiter #(
    parameter int N_ENGINES      = 4,
    parameter int SRCW           = 64,
    parameter int CTXW           = 9,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_ENGINES-1:0]      eng_intr_req,
    input  logic [N_ENGINES*SRCW-1:0] eng_intr_src,
    input  logic [N_ENGINES*CTXW-1:0] eng_intr_ctx,
    output logic [N_ENGINES-1:0]      eng_intr_ack,
    output logic                      intr_req,
    output logic [SRCW-1:0]           intr_src,
    output logic [CTXW-1:0]           intr_ctx,
    input  logic                      intr_ack,
    output logic [N_ENGINES-1:0]      pending,
    output logic [N_ENGINES-1:0]      err_overflow,
    output logic [N_ENGINES-1:0]      err_timeout,
    input  logic                      err_clr,
    output logic                      busy
);

    localparam int PTRW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [PTRW-1:0]        grant_q, grant_d;
    logic [PTRW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   intr_req_q, intr_req_d;
    logic [SRCW-1:0]        intr_src_q, intr_src_d;
    logic [CTXW-1:0]        intr_ctx_q, intr_ctx_d;
    logic [N_ENGINES-1:0]   eng_ack_q, eng_ack_d;
    logic [N_ENGINES-1:0]   pending_q, pending_d;
    logic [N_ENGINES-1:0]   err_overflow_q, err_overflow_d;
    logic [SRCW-1:0]        src_q [N_ENGINES];
    logic [SRCW-1:0]        src_d [N_ENGINES];
    logic [CTXW-1:0]        ctx_q [N_ENGINES];
    logic [CTXW-1:0]        ctx_d [N_ENGINES];

    // Per-engine strobes produced by the FSM in the cycle a grant retires.
    logic [N_ENGINES-1:0]   retire;
    logic [N_ENGINES-1:0]   ovf_set;
    logic                   expire;

`ifdef INTR_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0]         tcnt_q, tcnt_d;
    logic [N_ENGINES-1:0]   to_set;
    logic [N_ENGINES-1:0]   err_timeout_q, err_timeout_d;
`else
    logic                   unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: first set bit at or above ptr, wrapping at N.
    // ------------------------------------------------------------------
    function automatic logic [PTRW-1:0] rr_pick(
        input logic [N_ENGINES-1:0] req,
        input logic [PTRW-1:0]      ptr
    );
        logic [PTRW-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_ENGINES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_ENGINES) begin
                idx = idx - N_ENGINES;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTRW'(idx);
            end
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration FSM (next-state and registered-output computation)
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        intr_req_d = intr_req_q;
        intr_src_d = intr_src_q;
        intr_ctx_d = intr_ctx_q;
        eng_ack_d  = '0;
        retire     = '0;
        expire     = 1'b0;
`ifdef INTR_ARB_TIMEOUT_EN
        tcnt_d     = tcnt_q;
        to_set     = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    grant_d    = rr_pick(pending_q, rr_ptr_q);
                    intr_src_d = src_q[grant_d];
                    intr_ctx_d = ctx_q[grant_d];
                    intr_req_d = 1'b1;
                    state_d    = ST_REQ;
`ifdef INTR_ARB_TIMEOUT_EN
                    tcnt_d     = '0;
`endif
                end
            end

            ST_REQ: begin
`ifdef INTR_ARB_TIMEOUT_EN
                tcnt_d = tcnt_q + 1'b1;
                // A real ack in the expiry cycle wins; it is not a timeout.
                expire = (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) && !intr_ack;
`endif
                if (intr_ack || expire) begin
                    intr_req_d = 1'b0;
                    state_d    = ST_ACK;
                    if (grant_q == PTRW'(N_ENGINES - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_q + 1'b1;
                    end
                    for (int i = 0; i < N_ENGINES; i++) begin
                        if (grant_q == PTRW'(i)) begin
                            retire[i]    = 1'b1;
                            eng_ack_d[i] = 1'b1;
`ifdef INTR_ARB_TIMEOUT_EN
                            to_set[i]    = expire;
`endif
                        end
                    end
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and overflow detection
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_ENGINES; i++) begin
            pending_d[i] = pending_q[i];
            src_d[i]     = src_q[i];
            ctx_d[i]     = ctx_q[i];
            ovf_set[i]   = 1'b0;
            // A slot that retires this cycle is free again, so a pulse
            // landing in that cycle is a fresh capture, not an overflow.
            if (eng_intr_req[i] && (!pending_q[i] || retire[i])) begin
                pending_d[i] = 1'b1;
                src_d[i]     = eng_intr_src[i*SRCW +: SRCW];
                ctx_d[i]     = eng_intr_ctx[i*CTXW +: CTXW];
            end else if (retire[i]) begin
                pending_d[i] = 1'b0;
            end
            if (eng_intr_req[i] && pending_q[i] && !retire[i]) begin
                ovf_set[i] = 1'b1;
            end
        end
        err_overflow_d = err_clr ? '0 : (err_overflow_q | ovf_set);
    end

`ifdef INTR_ARB_TIMEOUT_EN
    always_comb begin
        err_timeout_d = err_clr ? '0 : (err_timeout_q | to_set);
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            intr_req_q     <= 1'b0;
            intr_src_q     <= '0;
            intr_ctx_q     <= '0;
            eng_ack_q      <= '0;
            pending_q      <= '0;
            err_overflow_q <= '0;
            for (int i = 0; i < N_ENGINES; i++) begin
                src_q[i] <= '0;
                ctx_q[i] <= '0;
            end
`ifdef INTR_ARB_TIMEOUT_EN
            tcnt_q         <= '0;
            err_timeout_q  <= '0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            intr_req_q     <= intr_req_d;
            intr_src_q     <= intr_src_d;
            intr_ctx_q     <= intr_ctx_d;
            eng_ack_q      <= eng_ack_d;
            pending_q      <= pending_d;
            err_overflow_q <= err_overflow_d;
            for (int i = 0; i < N_ENGINES; i++) begin
                src_q[i] <= src_d[i];
                ctx_q[i] <= ctx_d[i];
            end
`ifdef INTR_ARB_TIMEOUT_EN
            tcnt_q         <= tcnt_d;
            err_timeout_q  <= err_timeout_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign eng_intr_ack = eng_ack_q;
    assign intr_req     = intr_req_q;
    assign intr_src     = intr_src_q;
    assign intr_ctx     = intr_ctx_q;
    assign pending      = pending_q;
    assign err_overflow = err_overflow_q;
    assign busy         = (|pending_q) || (state_q != ST_IDLE);
`ifdef INTR_ARB_TIMEOUT_EN
    assign err_timeout  = err_timeout_q;
`else
    assign err_timeout  = '0;
`endif

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: capture latency, round-robin order,
// overflow/err_clr, capture in the retire cycle, reset mid-request, and the
// optional upstream ack timeout when INTR_ARB_TIMEOUT_EN is defined.
module tb_interrupt_arbiter;
  localparam int N    = 4;
  localparam int SRCW = 64;
  localparam int CTXW = 9;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         eng_intr_req;
  logic [N*SRCW-1:0]    eng_intr_src;
  logic [N*CTXW-1:0]    eng_intr_ctx;
  logic [N-1:0]         eng_intr_ack;
  logic                 intr_req;
  logic [SRCW-1:0]      intr_src;
  logic [CTXW-1:0]      intr_ctx;
  logic                 intr_ack;
  logic [N-1:0]         pending;
  logic [N-1:0]         err_overflow;
  logic [N-1:0]         err_timeout;
  logic                 err_clr;
  logic                 busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [SRCW-1:0] src_tab [N];
  logic [CTXW-1:0] ctx_tab [N];

  interrupt_arbiter #(
    .N_ENGINES      (N),
    .SRCW           (SRCW),
    .CTXW           (CTXW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .eng_intr_req (eng_intr_req),
    .eng_intr_src (eng_intr_src),
    .eng_intr_ctx (eng_intr_ctx),
    .eng_intr_ack (eng_intr_ack),
    .intr_req     (intr_req),
    .intr_src     (intr_src),
    .intr_ctx     (intr_ctx),
    .intr_ack     (intr_ack),
    .pending      (pending),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout),
    .err_clr      (err_clr),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    eng_intr_req = '0;
    intr_ack     = 1'b0;
    err_clr      = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load_slot(input int i);
    eng_intr_src[i*SRCW +: SRCW] = src_tab[i];
    eng_intr_ctx[i*CTXW +: CTXW] = ctx_tab[i];
  endtask

  // One-cycle request pulse on every engine set in mask, from the tables.
  task automatic pulse(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) load_slot(i);
    end
    eng_intr_req = mask;
    step();
    eng_intr_req = '0;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (intr_req !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    check_eq({tag, "_req_seen"}, {63'd0, intr_req}, 64'd1);
  endtask

  // Expect engine e to be granted next; ack it immediately and check the
  // returned engine ack.
  task automatic serve(input int e, input string tag);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[e] = 1'b1;
    wait_req(tag);
    check_eq({tag, "_src"}, intr_src, src_tab[e]);
    check_eq({tag, "_ctx"}, {55'd0, intr_ctx}, {55'd0, ctx_tab[e]});
    intr_ack = 1'b1;
    step();
    intr_ack = 1'b0;
    check_eq({tag, "_eng_ack"}, {60'd0, eng_intr_ack}, {60'd0, onehot});
    check_eq({tag, "_req_drop"}, {63'd0, intr_req}, 64'd0);
  endtask

  // ---------------- stimulus + checks ----------------
  initial begin
    logic [N-1:0]    acc;
    logic [SRCW-1:0] first_src;

    src_tab[0] = 64'h1111_0000_0000_00A0;
    src_tab[1] = 64'h2222_0000_0000_00A1;
    src_tab[2] = 64'h0000_0001_0000_0004;
    src_tab[3] = 64'h4444_0000_0000_00A3;
    ctx_tab[0] = 9'h010;
    ctx_tab[1] = 9'h111;
    ctx_tab[2] = 9'h005;
    ctx_tab[3] = 9'h1F3;
    eng_intr_src = '0;
    eng_intr_ctx = '0;

    // ---- reset values ----
    do_reset();
    check_eq("rst_intr_req", {63'd0, intr_req}, 64'd0);
    check_eq("rst_eng_ack", {60'd0, eng_intr_ack}, 64'd0);
    check_eq("rst_pending", {60'd0, pending}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_err_ovf", {60'd0, err_overflow}, 64'd0);
    check_eq("rst_err_to", {60'd0, err_timeout}, 64'd0);
    check_eq("rst_src", intr_src, 64'd0);

    // ---- single request on engine 2: 2-cycle latency, ack 3 cycles later ----
    pulse(4'b0100);
    check_eq("t1_pending", {60'd0, pending}, 64'h4);
    check_eq("t1_req_c1", {63'd0, intr_req}, 64'd0);
    step();
    check_eq("t1_req_c2", {63'd0, intr_req}, 64'd1);
    check_eq("t1_src", intr_src, 64'h0000_0001_0000_0004);
    check_eq("t1_ctx", {55'd0, intr_ctx}, 64'h5);
    step();
    step();
    check_eq("t1_req_held", {63'd0, intr_req}, 64'd1);
    check_eq("t1_src_held", intr_src, 64'h0000_0001_0000_0004);
    step();
    intr_ack = 1'b1;
    check_eq("t1_no_early_ack", {60'd0, eng_intr_ack}, 64'd0);
    step();
    intr_ack = 1'b0;
    check_eq("t1_eng_ack", {60'd0, eng_intr_ack}, 64'h4);
    check_eq("t1_req_drop", {63'd0, intr_req}, 64'd0);
    check_eq("t1_pending_clr", {60'd0, pending}, 64'd0);
    step();
    check_eq("t1_eng_ack_once", {60'd0, eng_intr_ack}, 64'd0);
    check_eq("t1_busy", {63'd0, busy}, 64'd0);

    // ---- round-robin: 0,1,3 then all four wrap to 0,1,2,3 ----
    do_reset();
    pulse(4'b1011);
    serve(0, "rr_a0");
    serve(1, "rr_a1");
    serve(3, "rr_a3");
    pulse(4'b1111);
    serve(0, "rr_b0");
    serve(1, "rr_b1");
    serve(2, "rr_b2");
    serve(3, "rr_b3");
    step();
    step();
    check_eq("rr_idle_busy", {63'd0, busy}, 64'd0);

    // ---- overflow on engine 1; upstream keeps first src; err_clr ----
    pulse(4'b0010);
    first_src = src_tab[1];
    eng_intr_src[1*SRCW +: SRCW] = 64'hDEAD_BEEF_0000_0001;
    eng_intr_req = 4'b0010;
    step();
    eng_intr_req = '0;
    check_eq("ovf_set", {60'd0, err_overflow}, 64'h2);
    serve(1, "ovf_first");
    check_eq("ovf_src_kept", first_src, src_tab[1]);
    check_eq("ovf_pending_clr", {60'd0, pending}, 64'd0);
    check_eq("ovf_sticky", {60'd0, err_overflow}, 64'h2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("ovf_clr", {60'd0, err_overflow}, 64'd0);

    // ---- new pulse on engine 0 in the cycle its grant retires ----
    pulse(4'b0001);
    wait_req("rt_first");
    check_eq("rt_first_src", intr_src, src_tab[0]);
    src_tab[0] = 64'h0BAD_CAFE_0000_0055;
    ctx_tab[0] = 9'h0AA;
    load_slot(0);
    eng_intr_req = 4'b0001;
    intr_ack     = 1'b1;
    step();
    eng_intr_req = '0;
    intr_ack     = 1'b0;
    check_eq("rt_pending_kept", {60'd0, pending}, 64'h1);
    check_eq("rt_eng_ack", {60'd0, eng_intr_ack}, 64'h1);
    check_eq("rt_no_ovf", {60'd0, err_overflow}, 64'd0);
    serve(0, "rt_second");
    check_eq("rt_no_ovf_end", {60'd0, err_overflow}, 64'd0);
    check_eq("rt_pending_end", {60'd0, pending}, 64'd0);

    // ---- reset while in REQ; then a stray intr_ack in IDLE ----
    do_reset();
    pulse(4'b1000);
    wait_req("mid_rst");
    reset = 1'b1;
    step();
    check_eq("mid_rst_req", {63'd0, intr_req}, 64'd0);
    check_eq("mid_rst_pending", {60'd0, pending}, 64'd0);
    check_eq("mid_rst_eng_ack", {60'd0, eng_intr_ack}, 64'd0);
    reset = 1'b0;
    acc = '0;
    for (int k = 0; k < 6; k++) begin
      intr_ack = (k == 2);
      step();
      acc = acc | eng_intr_ack;
      acc[0] = acc[0] | intr_req;
    end
    intr_ack = 1'b0;
    check_eq("mid_rst_quiet", {60'd0, acc}, 64'd0);
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("no_timeout_err", {60'd0, err_timeout}, 64'd0);

`ifdef INTR_ARB_TIMEOUT_EN
    // ---- upstream ack withheld: timeout after 16 REQ cycles ----
    begin
      int hi;
      do_reset();
      pulse(4'b0110);
      wait_req("to");
      check_eq("to_src", intr_src, src_tab[1]);
      hi = 0;
      while (intr_req === 1'b1 && hi < 40) begin
        hi++;
        step();
      end
      check_eq("to_req_cycles", 64'(hi), 64'd16);
      check_eq("to_eng_ack", {60'd0, eng_intr_ack}, 64'h2);
      check_eq("to_err", {60'd0, err_timeout}, 64'h2);
      serve(2, "to_next");
      check_eq("to_err_sticky", {60'd0, err_timeout}, 64'h2);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_eq("to_err_clr", {60'd0, err_timeout}, 64'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
